// File: rtl/oam_dma_controller_pkg.sv
// Shared definitions for the OAM DMA engine: register map, OAM geometry,
// echo-RAM fold mask, FSM encoding and the source-address mapping helper.
package oam_dma_controller_pkg;

    localparam logic [15:0] OAM_DMA_REG = 16'hFF46;
    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam int          OAM_LEN     = 160;
    localparam logic [15:0] ECHO_MASK   = 16'hDFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } dma_state_t;

    // Pages E0..FF mirror C0..DF, so the fetch address folds back onto work RAM.
    function automatic logic [15:0] map_src_addr(input logic [7:0] src, input logic [7:0] idx);
        logic [15:0] raw;
        raw = {src, idx};
        return (src >= 8'hE0) ? (raw & ECHO_MASK) : raw;
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine behind FF46: copies {src,00..LENGTH-1} into OAM one byte at a time.
// Define OAM_DMA_RESTART_EN to let an FF46 write restart a transfer already in flight.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] REG_ADDR     = OAM_DMA_REG,
    parameter logic [15:0] DEST_BASE    = OAM_BASE,
    parameter int          LENGTH       = OAM_LEN,
    parameter int          START_DELAY  = 1,
    parameter int          READ_LATENCY = 1
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_IOREG_ADDR,
    input  logic [7:0]  I_IOREG_WDATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    output logic [7:0]  O_IOREG_RDATA,
    output logic [15:0] O_RDMA_ADDR,
    output logic        O_RDMA_RE_L,
    input  logic [7:0]  I_RDMA_DATA,
    output logic [15:0] O_WDMA_ADDR,
    output logic [7:0]  O_WDMA_DATA,
    output logic        O_WDMA_WE_L,
    output logic        O_DMA_ACTIVE,
    output logic        O_DMA_DONE
);

    localparam int               CNT_W       = 8;
    localparam logic [7:0]       LAST_IDX    = 8'(LENGTH - 1);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(READ_LATENCY - 1);
    localparam dma_state_t       FIRST_STATE = (START_DELAY == 0) ? ST_READ : ST_START;

    dma_state_t       state, state_n;
    logic [7:0]       src, src_n;
    logic [7:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      rdma_addr, rdma_addr_n;
    logic [15:0]      wdma_addr, wdma_addr_n;
    logic [7:0]       wdma_data, wdma_data_n;
    logic             trigger;
    logic             dma_active;
    logic             accept;

    assign trigger    = !I_IOREG_WE_L && (I_IOREG_ADDR == REG_ADDR);
    assign dma_active = (state == ST_START) || (state == ST_READ) ||
                        (state == ST_WAIT)  || (state == ST_WRITE);

`ifdef OAM_DMA_RESTART_EN
    assign accept = trigger;
`else
    assign accept = trigger && !dma_active;
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state     <= ST_IDLE;
            src       <= 8'h00;
            idx       <= 8'h00;
            cnt       <= '0;
            rdma_addr <= 16'h0000;
            wdma_addr <= 16'h0000;
            wdma_data <= 8'h00;
        end else begin
            state     <= state_n;
            src       <= src_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            rdma_addr <= rdma_addr_n;
            wdma_addr <= wdma_addr_n;
            wdma_data <= wdma_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        src_n       = src;
        idx_n       = idx;
        cnt_n       = cnt;
        rdma_addr_n = rdma_addr;
        wdma_addr_n = wdma_addr;
        wdma_data_n = wdma_data;

        case (state)
            ST_START: begin
                if (cnt == START_LAST) state_n = ST_READ;
                else                   cnt_n   = cnt + 1'b1;
            end
            ST_READ: begin
                state_n = ST_WAIT;
                cnt_n   = '0;
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_n     = ST_WRITE;
                    wdma_addr_n = DEST_BASE + {8'h00, idx};
                    wdma_data_n = I_RDMA_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_WRITE: begin
                if (idx == LAST_IDX) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx + 8'd1;
                    state_n = ST_READ;
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase

        // An accepted trigger overrides whatever the sequencer was about to do.
        if (accept) begin
            src_n   = I_IOREG_WDATA;
            idx_n   = 8'h00;
            cnt_n   = '0;
            state_n = FIRST_STATE;
        end

        // Read address is registered on entry to READ so it is stable for the whole strobe.
        if (state_n == ST_READ) rdma_addr_n = map_src_addr(src_n, idx_n);
    end

    assign O_RDMA_ADDR   = rdma_addr;
    assign O_RDMA_RE_L   = (state != ST_READ);
    assign O_WDMA_ADDR   = wdma_addr;
    assign O_WDMA_DATA   = wdma_data;
    assign O_WDMA_WE_L   = (state != ST_WRITE);
    assign O_DMA_ACTIVE  = dma_active;
    assign O_DMA_DONE    = (state == ST_DONE);
    assign O_IOREG_RDATA = (!I_IOREG_RE_L && (I_IOREG_ADDR == REG_ADDR)) ? src : 8'hFF;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: instance 0 uses default timing, instance 1 a 3-cycle read latency.
// Expected OAM contents come from a page-copy model with a keyed memory pattern.
module tb_oam_dma_controller;

    localparam int LEN = 160;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] io_addr  [2];
    logic [7:0]  io_wdata [2];
    logic        io_we_l  [2];
    logic        io_re_l  [2];
    logic [7:0]  io_rdata [2];
    logic [15:0] rd_addr  [2];
    logic        re_l     [2];
    logic [7:0]  rd_data  [2];
    logic [15:0] wr_addr  [2];
    logic [7:0]  wr_data  [2];
    logic        we_l     [2];
    logic        active   [2];
    logic        done     [2];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  key      [2];
    logic        hv       [2][4];
    logic [15:0] ha       [2][4];
    int          overlap  [2];
    int          active_cnt [2];
    int          done_cnt [2];
    time         done_t   [2];
    time         t_trig   [2];

    logic [23:0] obs_a[$];
    logic [23:0] obs_b[$];
    logic [15:0] rd_a[$];
    logic [15:0] rd_b[$];
    logic [23:0] exp_q[$];
    logic [15:0] exp_rd_q[$];

    always #5 clk = ~clk;

    oam_dma_controller u_dut0 (
        .I_CLK(clk), .I_RESET(rst),
        .I_IOREG_ADDR(io_addr[0]), .I_IOREG_WDATA(io_wdata[0]),
        .I_IOREG_WE_L(io_we_l[0]), .I_IOREG_RE_L(io_re_l[0]), .O_IOREG_RDATA(io_rdata[0]),
        .O_RDMA_ADDR(rd_addr[0]), .O_RDMA_RE_L(re_l[0]), .I_RDMA_DATA(rd_data[0]),
        .O_WDMA_ADDR(wr_addr[0]), .O_WDMA_DATA(wr_data[0]), .O_WDMA_WE_L(we_l[0]),
        .O_DMA_ACTIVE(active[0]), .O_DMA_DONE(done[0])
    );

    oam_dma_controller #(.READ_LATENCY(3)) u_dut1 (
        .I_CLK(clk), .I_RESET(rst),
        .I_IOREG_ADDR(io_addr[1]), .I_IOREG_WDATA(io_wdata[1]),
        .I_IOREG_WE_L(io_we_l[1]), .I_IOREG_RE_L(io_re_l[1]), .O_IOREG_RDATA(io_rdata[1]),
        .O_RDMA_ADDR(rd_addr[1]), .O_RDMA_RE_L(re_l[1]), .I_RDMA_DATA(rd_data[1]),
        .O_WDMA_ADDR(wr_addr[1]), .O_WDMA_DATA(wr_data[1]), .O_WDMA_WE_L(we_l[1]),
        .O_DMA_ACTIVE(active[1]), .O_DMA_DONE(done[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic [7:0] k);
        return a[7:0] ^ k;
    endfunction

    // Source page after echo folding: E0..FF mirror 32 pages lower.
    function automatic logic [15:0] src_addr(input logic [7:0] src, input int i);
        logic [7:0] hi;
        hi = (src >= 8'hE0) ? (src - 8'h20) : src;
        return {hi, 8'(i)};
    endfunction

    function automatic int xfer_cycles(input int d);
        return 1 + LEN * (lat(d) + 2);
    endfunction

    // Observer plus memory responder; data is valid only exactly lat() cycles after the read strobe.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!we_l[d]) begin
                if (d == 0) obs_a.push_back({wr_addr[d], wr_data[d]});
                else        obs_b.push_back({wr_addr[d], wr_data[d]});
            end
            if (!re_l[d]) begin
                if (d == 0) rd_a.push_back(rd_addr[d]);
                else        rd_b.push_back(rd_addr[d]);
            end
            if (!re_l[d] && !we_l[d]) overlap[d]++;
            if (active[d]) active_cnt[d]++;
            if (done[d]) begin
                done_cnt[d]++;
                done_t[d] = $time;
            end
            for (int k = 3; k > 0; k--) begin
                hv[d][k] = hv[d][k-1];
                ha[d][k] = ha[d][k-1];
            end
            hv[d][0] = !re_l[d];
            ha[d][0] = rd_addr[d];
            rd_data[d] = hv[d][lat(d)] ? mem_byte(ha[d][lat(d)], key[d])
                                       : ~mem_byte(ha[d][lat(d)], key[d]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_b.delete(); rd_a.delete(); rd_b.delete();
        exp_q.delete(); exp_rd_q.delete();
        for (int d = 0; d < 2; d++) begin
            overlap[d] = 0; active_cnt[d] = 0; done_cnt[d] = 0; done_t[d] = 0;
        end
    endtask

    task automatic build_exp(input logic [7:0] src, input logic [7:0] k, input int count);
        for (int i = 0; i < count; i++) begin
            exp_rd_q.push_back(src_addr(src, i));
            exp_q.push_back({16'hFE00 + 16'(i), mem_byte(src_addr(src, i), k)});
        end
    endtask

    task automatic io_write(input int d, input logic [15:0] a, input logic [7:0] v);
        io_addr[d]  = a;
        io_wdata[d] = v;
        io_we_l[d]  = 1'b0;
        @(posedge clk);
        t_trig[d] = $time;
        @(negedge clk);
        #1;
        io_we_l[d] = 1'b1;
        io_addr[d] = 16'h0000;
    endtask

    task automatic io_read_check(input int d, input logic [15:0] a, input logic [7:0] v, input string tag);
        io_addr[d] = a;
        io_re_l[d] = 1'b0;
        #1;
        check(tag, 32'(io_rdata[d]), 32'(v));
        io_re_l[d] = 1'b1;
        io_addr[d] = 16'h0000;
    endtask

    task automatic wait_done(input int d, input int budget, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (done_cnt[d] > 0) begin
                seen = 1;
                break;
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        step(4);
    endtask

    task automatic compare_streams(input int d, input string tag);
        int n;
        int m;
        n = (d == 0) ? obs_a.size() : obs_b.size();
        m = (d == 0) ? rd_a.size() : rd_b.size();
        check({tag, " write count"}, 32'(n), 32'(exp_q.size()));
        check({tag, " read count"}, 32'(m), 32'(exp_rd_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s write %0d", tag, i),
                  32'((d == 0) ? obs_a[i] : obs_b[i]), 32'(exp_q[i]));
        for (int i = 0; i < exp_rd_q.size() && i < m; i++)
            check($sformatf("%s read %0d", tag, i),
                  32'((d == 0) ? rd_a[i] : rd_b[i]), 32'(exp_rd_q[i]));
    endtask

    function automatic int cycle_of(input int d, input time tref);
        return int'((done_t[d] - tref - 5) / 10) + 1;
    endfunction

    task automatic run_transfer(input int d, input logic [7:0] src, input logic [7:0] k, input string tag);
        clear_obs();
        key[d] = k;
        build_exp(src, k, LEN);
        io_write(d, 16'hFF46, src);
        wait_done(d, 2000, tag);
        compare_streams(d, tag);
        check({tag, " done pulses"}, 32'(done_cnt[d]), 32'd1);
        check({tag, " done cycle"}, 32'(cycle_of(d, t_trig[d])), 32'(xfer_cycles(d) + 1));
        check({tag, " active cycles"}, 32'(active_cnt[d]), 32'(xfer_cycles(d)));
        check({tag, " strobe overlap"}, 32'(overlap[d]), 32'd0);
    endtask

    initial begin
        logic [7:0] rsrc;
        int         fe_hits;
        time        t_first;

        for (int d = 0; d < 2; d++) begin
            io_addr[d] = 16'h0000; io_wdata[d] = 8'h00;
            io_we_l[d] = 1'b1;     io_re_l[d]  = 1'b1;
            key[d] = 8'h00; rd_data[d] = 8'h00;
            for (int k = 0; k < 4; k++) begin
                hv[d][k] = 1'b0;
                ha[d][k] = 16'h0000;
            end
        end
        clear_obs();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1);

        check("reset re_l", 32'(re_l[0]), 32'd1);
        check("reset we_l", 32'(we_l[0]), 32'd1);
        check("reset rdma addr", 32'(rd_addr[0]), 32'd0);
        check("reset wdma addr", 32'(wr_addr[0]), 32'd0);
        check("reset wdma data", 32'(wr_data[0]), 32'd0);
        check("reset active", 32'(active[0]), 32'd0);
        check("reset done", 32'(done[0]), 32'd0);
        io_read_check(0, 16'hFF46, 8'h00, "reset readback");

        // Readback register while a transfer from page 47 is running.
        clear_obs();
        key[0] = 8'(($urandom_range(255, 0)));
        build_exp(8'h47, key[0], LEN);
        io_write(0, 16'hFF46, 8'h47);
        check("active after trigger", 32'(active[0]), 32'd1);
        io_read_check(0, 16'hFF46, 8'h47, "readback ff46");
        io_read_check(0, 16'hFF47, 8'hFF, "readback ff47");
        wait_done(0, 2000, "src47");
        compare_streams(0, "src47");

        run_transfer(0, 8'hC1, 8'h5A, "srcC1");
        check("srcC1 first byte", 32'(obs_a[0]), 32'h00FE005A);
        check("srcC1 last byte", 32'(obs_a[LEN-1]), 32'h00FE9FC5);

        run_transfer(0, 8'hFE, 8'h5A, "srcFE");
        fe_hits = 0;
        foreach (rd_a[i]) if (rd_a[i][15:8] == 8'hFE) fe_hits++;
        check("srcFE reads of FExx", 32'(fe_hits), 32'd0);

        for (int r = 0; r < 3; r++) begin
            rsrc = 8'($urandom_range(255, 0));
            run_transfer(0, rsrc, 8'($urandom_range(255, 0)), $sformatf("rand%0d src%02h", r, rsrc));
        end

        // Second FF46 write of 80 lands on the edge that ends byte 50's write cycle.
        clear_obs();
        key[0] = 8'h5A;
`ifdef OAM_DMA_RESTART_EN
        build_exp(8'hC1, 8'h5A, 51);
        build_exp(8'h80, 8'h5A, LEN);
`else
        build_exp(8'hC1, 8'h5A, LEN);
`endif
        io_write(0, 16'hFF46, 8'hC1);
        t_first = t_trig[0];
        step(153);
        check("restart lands in write", 32'({we_l[0], wr_addr[0]}), 32'({1'b0, 16'hFE32}));
        io_write(0, 16'hFF46, 8'h80);
        wait_done(0, 2000, "restart");
        compare_streams(0, "restart");
        check("restart done pulses", 32'(done_cnt[0]), 32'd1);
`ifdef OAM_DMA_RESTART_EN
        check("restart done cycle", 32'(cycle_of(0, t_trig[0])), 32'(xfer_cycles(0) + 1));
        check("restart active cycles", 32'(active_cnt[0]), 32'(153 + 1 + xfer_cycles(0)));
        io_read_check(0, 16'hFF46, 8'h80, "restart readback");
`else
        check("restart done cycle", 32'(cycle_of(0, t_first)), 32'(xfer_cycles(0) + 1));
        check("restart active cycles", 32'(active_cnt[0]), 32'(xfer_cycles(0)));
        io_read_check(0, 16'hFF46, 8'hC1, "restart readback");
`endif

        // Reset asserted while byte 10 is being written.
        clear_obs();
        key[0] = 8'h3C;
        build_exp(8'hC1, 8'h3C, 11);
        io_write(0, 16'hFF46, 8'hC1);
        step(33);
        check("reset point in write", 32'({we_l[0], wr_addr[0]}), 32'({1'b0, 16'hFE0A}));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort re_l", 32'(re_l[0]), 32'd1);
        check("abort we_l", 32'(we_l[0]), 32'd1);
        check("abort active", 32'(active[0]), 32'd0);
        check("abort done", 32'(done[0]), 32'd0);
        check("abort wdma addr", 32'(wr_addr[0]), 32'd0);
        step(20);
        compare_streams(0, "abort");
        fe_hits = 0;
        foreach (obs_a[i]) if (obs_a[i][23:8] == 16'hFE0B) fe_hits++;
        check("abort no FE0B write", 32'(fe_hits), 32'd0);
        check("abort no done", 32'(done_cnt[0]), 32'd0);
        io_read_check(0, 16'hFF46, 8'h00, "abort readback");

        // Three-cycle read latency: 5 cycles per byte, off-cycle data is corrupted by the responder.
        rsrc = 8'($urandom_range(255, 0));
        run_transfer(1, rsrc, 8'($urandom_range(255, 0)), "lat3");
        run_transfer(1, 8'hC1, 8'h5A, "lat3 srcC1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- OAM DMA engine for the FF46 register.
- Sits directly upstream of the memory router and is the sole master on its DMA read port and DMA write port.
- A CPU write to FF46 with value XX copies XX00–XX9F into OAM at FE00–FE9F, one byte at a time.
- O_DMA_ACTIVE is exported so the CPU side can be stalled or blocked.

Parameters:
- REG_ADDR, 16'hFF46, trigger/readback register address.
- DEST_BASE, 16'hFE00, OAM destination base.
- LENGTH, 160, bytes per transfer.
- START_DELAY, 1, idle cycles between trigger and first read.
- READ_LATENCY, 1, cycles from O_RDMA_RE_L low to I_RDMA_DATA valid (at least 1).

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  reset
- I_IOREG_ADDR  in  16  IO register bus address
- I_IOREG_WDATA  in  8  IO register write data
- I_IOREG_WE_L  in  1  IO register write strobe, active low
- I_IOREG_RE_L  in  1  IO register read strobe, active low
- O_IOREG_RDATA  out  8  readback data
- O_RDMA_ADDR  out  16  router DMA read address
- O_RDMA_RE_L  out  1  router DMA read enable, active low
- I_RDMA_DATA  in  8  router DMA read data
- O_WDMA_ADDR  out  16  router DMA write address
- O_WDMA_DATA  out  8  router DMA write data
- O_WDMA_WE_L  out  1  router DMA write enable, active low
- O_DMA_ACTIVE  out  1  transfer in progress
- O_DMA_DONE  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock I_CLK. I_RESET is synchronous and active-high. Every register updates on the I_CLK rising edge.
- Reset values:
  - *_RE_L and *_WE_L = 1.
  - O_RDMA_ADDR, O_WDMA_ADDR, O_WDMA_DATA = 0.
  - O_DMA_ACTIVE, O_DMA_DONE = 0.
  - Source register = 8'h00, byte index = 0, state = IDLE.
- Trigger: I_IOREG_WE_L==0 and I_IOREG_ADDR==REG_ADDR at a clock edge.
  - Latch I_IOREG_WDATA into the source register.
  - idx <= 0; state <= START.
  - O_DMA_ACTIVE rises the next cycle.
- Source mapping: read address = {src,idx[7:0]} & 16'hDFFF when src >= 8'hE0 (echo-RAM fold); otherwise unmodified.
- FSM:
  - IDLE: all strobes inactive.
  - START: hold START_DELAY cycles, then go to READ.
  - READ: one cycle. O_RDMA_RE_L=0, O_RDMA_ADDR=mapped source address. Go to WAIT.
  - WAIT: READ_LATENCY cycles, RE_L=1. Capture I_RDMA_DATA at the edge ending the last WAIT cycle. Go to WRITE.
  - WRITE: one cycle. O_WDMA_WE_L=0, O_WDMA_ADDR=DEST_BASE+idx, O_WDMA_DATA=captured byte.
    - If idx==LENGTH-1: go to DONE.
    - Else: idx+1, go to READ.
  - DONE: one cycle. O_DMA_DONE=1, O_DMA_ACTIVE=0. Go to IDLE.
- Timing:
  - Per byte: READ_LATENCY+2 cycles.
  - Full transfer: START_DELAY + LENGTH*(READ_LATENCY+2) cycles; 481 at defaults.
- O_DMA_ACTIVE: high from the cycle after trigger through the last WRITE cycle inclusive.
- RE_L and WE_L are never low in the same cycle. Addresses and data are registered outputs with no combinational path from inputs.
- Readback: O_IOREG_RDATA = source register when I_IOREG_RE_L==0 and address matches; else 8'hFF (combinational).
- Trigger while active (macro off): write ignored entirely; transfer continues unchanged.
- Reset mid-transfer: abort on that edge; outputs return to reset values; no further write issued.
- Simultaneous reset and trigger: reset wins.

Optional Feature:
- Macro: OAM_DMA_RESTART_EN.
- Defined: a trigger while O_DMA_ACTIVE=1 does the following.
  - Updates the source register.
  - Sets idx=0 and state=START, discarding any pending read data.
  - A WRITE occurring in the trigger cycle still completes.
  - O_DMA_ACTIVE stays high continuously; no O_DMA_DONE for the aborted transfer.
- Undefined: the trigger is ignored while active, as above.

Decomposition:
- Shared header (memdef): OAM_DMA_REG 16'hFF46, OAM_BASE 16'hFE00, OAM_LEN 160, ECHO_MASK 16'hDFFF, FSM state encodings (IDLE, START, READ, WAIT, WRITE, DONE).
- No sub-module: the FSM, byte counter and latency counter are inline.

Test Plan:
- Write 8'hC1 to FF46, model returns mem[addr]=addr[7:0]^8'h5A:
  - 160 writes, FE00..FE9F.
  - FE00 receives 8'h5A, FE9F receives 8'hC5.
  - Reads cover C100..C19F.
  - O_DMA_DONE pulses at cycle 482 after the trigger; O_DMA_ACTIVE spans 481 cycles.
- Source 8'hFE: reads cover DE00..DE9F; never FE00.
- READ_LATENCY=3:
  - 5 cycles per byte.
  - Data captured exactly 3 cycles after RE_L falls.
  - Wrong-cycle model data is not written.
- Second FF46 write of 8'h80 at byte 50, macro off: transfer still copies C100-based data to completion. Macro on: idx restarts at 0; reads 8000.., FE00 rewritten; single DONE.
- I_RESET asserted during WRITE of byte 10: next cycle all strobes=1, ACTIVE=0; no write to FE0B; readback returns 8'h00.
- Read FF46 after writing 8'h47: O_IOREG_RDATA=8'h47. Read FF47: 8'hFF.
